pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum number of consecutive data-memory wait cycles before bus_error.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_read_en_1 / id_read_en_2  in  1  ID stage reads operand register 1 / 2.
REQ-005 SHALL have ports id_read_addr_1 / id_read_addr_2  in  5  ID source register indices.
REQ-006 SHALL have ports ex_write_en / ex_load_flag / ex_write_addr  in  1/1/5  EX-stage writeback intent, load flag, destination.
REQ-007 SHALL have ports mem_write_en / mem_write_addr  in  1/5  MEM-stage writeback intent and destination.
REQ-008 SHALL have ports mem_req / mem_ready  in  1/1  data-memory request issued and completed this cycle.
REQ-009 SHALL have ports rom_req / rom_ready  in  1/1  instruction-fetch request and completion.
REQ-010 SHALL have port stall_cnt_clr  in  1  clears stall_count.
REQ-011 SHALL have port stall  out  6  hold per stage; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-012 SHALL have ports id_bubble / ex_bubble  out  1/1  insert NOP into ID / EX on next edge.
REQ-013 SHALL have ports fwd_sel_1 / fwd_sel_2  out  2/2  operand source: 00 register file, 01 EX result, 10 MEM result.
REQ-014 SHALL have port bus_error  out  1  one-cycle pulse on data-memory timeout.
REQ-015 SHALL have port stall_count  out  16  saturating count of cycles with stall[0] asserted.

Function
REQ-016 Forwarding SHALL be combinational: for operand n, fwd_sel_n=01 if id_read_en_n, ex_write_en, !ex_load_flag, ex_write_addr==id_read_addr_n, addr!=0; else 10 if id_read_en_n, mem_write_en, mem_write_addr==id_read_addr_n, addr!=0; else 00.
REQ-017 EX match SHALL take priority over MEM match; register 0 SHALL never forward or hazard.
REQ-018 Load-use hazard SHALL be asserted when either enabled operand matches ex_write_addr (non-zero) with ex_write_en and ex_load_flag high.
REQ-019 Memory wait SHALL be asserted when mem_req && !mem_ready; fetch wait when rom_req && !rom_ready.
REQ-020 Memory wait SHALL set stall=011111, ex_bubble=0, id_bubble=0, overriding all other causes.
REQ-021 Load-use without memory wait SHALL set stall=000111, ex_bubble=1, id_bubble=0, overriding fetch wait.
REQ-022 Fetch wait alone SHALL set stall=000011, id_bubble=1.
REQ-023 No cause SHALL give stall=0, both bubbles 0; all stall/bubble outputs are combinational, zero latency.
REQ-024 FSM states SHALL be RUN and MEM_WAIT; RUN->MEM_WAIT on memory wait; MEM_WAIT->RUN on mem_ready or !mem_req.
REQ-025 An 8-bit-minimum wait counter SHALL clear on RUN entry, increment each MEM_WAIT cycle with memory wait.
REQ-026 When the wait counter reaches MEM_TIMEOUT, bus_error SHALL pulse high next cycle, counter SHALL restart at 0, state stays MEM_WAIT if still waiting (repeat pulses every MEM_TIMEOUT cycles).
REQ-027 mem_ready arriving in the timeout cycle SHALL win: no bus_error, return to RUN.
REQ-028 stall_count SHALL increment when stall[0]=1, saturate at 0xFFFF; stall_cnt_clr SHALL take priority over increment (count reads 0 next cycle).

Reset
REQ-029 rst SHALL force state RUN, wait counter 0, bus_error 0, stall_count 0 on the next edge, aborting any in-progress wait.
REQ-030 During rst high, bus_error SHALL be 0; combinational outputs follow inputs.

Structure
REQ-031 State encodings, stall bit indices and fwd_sel codes SHALL live in the shared include alongside bus.v definitions.
REQ-032 Combinational forwarding/hazard logic SHALL be sub-module hazard_detect; FSM, counters, priority mux in pipeline_ctrl.

Verification
REQ-033 ex_write_en=1, ex_load_flag=0, ex_write_addr=5, id_read_addr_1=5, mem also 5 -> fwd_sel_1=01, stall=0.
REQ-034 ex_load_flag=1, ex_write_addr=8, id_read_addr_2=8 -> stall=000111, ex_bubble=1; same with addr 0 -> stall=0.
REQ-035 mem_req=1, mem_ready=0 held 3 cycles plus load-use and rom wait -> stall=011111 each cycle, stall_count +3.
REQ-036 MEM_TIMEOUT=4, mem_ready held 0 for 10 cycles -> bus_error pulses exactly twice, stall held throughout.
REQ-037 rst asserted mid MEM_WAIT -> next cycle state RUN, stall_count 0, no bus_error.
REQ-038 stall_count preloaded to 0xFFFF by long stall -> stays 0xFFFF; stall_cnt_clr with stall high -> 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, stall bit positions,
// forwarding source codes, and the per-operand forwarding selector.
package pipeline_ctrl_pkg;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Stall vector bit positions; bit 5 is WB and is never held by this controller.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_FETCH = 6'((1 << STALL_PC) | (1 << STALL_IF));
  localparam logic [5:0] STALL_LOAD  = 6'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));
  localparam logic [5:0] STALL_DMEM  = 6'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID)
                                          | (1 << STALL_EX) | (1 << STALL_MEM));

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       en;
    logic [4:0] addr;
  } wb_intent_t;

  // A load in EX has no result yet, so it can only be served from MEM or stall.
  function automatic logic [1:0] fwd_select(
    input logic       rd_en,
    input logic [4:0] rd_addr,
    input wb_intent_t ex_wb,
    input logic       ex_load,
    input wb_intent_t mem_wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rd_en && rd_addr != 5'd0) begin
      if (ex_wb.en && !ex_load && ex_wb.addr == rd_addr)
        sel = FWD_EX;
      else if (mem_wb.en && mem_wb.addr == rd_addr)
        sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational operand forwarding and load-use hazard detection for the ID stage.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       id_read_en_1,
  input  logic       id_read_en_2,
  input  logic [4:0] id_read_addr_1,
  input  logic [4:0] id_read_addr_2,
  input  logic       ex_write_en,
  input  logic       ex_load_flag,
  input  logic [4:0] ex_write_addr,
  input  logic       mem_write_en,
  input  logic [4:0] mem_write_addr,
  output logic [1:0] fwd_sel_1,
  output logic [1:0] fwd_sel_2,
  output logic       load_use
);

  wb_intent_t ex_wb;
  wb_intent_t mem_wb;
  logic       load_hit_1;
  logic       load_hit_2;

  assign ex_wb  = '{en: ex_write_en, addr: ex_write_addr};
  assign mem_wb = '{en: mem_write_en, addr: mem_write_addr};

  assign fwd_sel_1 = fwd_select(id_read_en_1, id_read_addr_1, ex_wb, ex_load_flag, mem_wb);
  assign fwd_sel_2 = fwd_select(id_read_en_2, id_read_addr_2, ex_wb, ex_load_flag, mem_wb);

  assign load_hit_1 = id_read_en_1 && (id_read_addr_1 == ex_write_addr);
  assign load_hit_2 = id_read_en_2 && (id_read_addr_2 == ex_write_addr);
  assign load_use   = ex_write_en && ex_load_flag && (ex_write_addr != 5'd0)
                      && (load_hit_1 || load_hit_2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/bubble controller with data-memory timeout and stall cycle counter.
//   state       | meaning
//   ST_RUN      | no outstanding data-memory wait; wait counter held at 0
//   ST_MEM_WAIT | data memory stalled; counting toward MEM_TIMEOUT
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_read_en_1,
  input  logic        id_read_en_2,
  input  logic [4:0]  id_read_addr_1,
  input  logic [4:0]  id_read_addr_2,
  input  logic        ex_write_en,
  input  logic        ex_load_flag,
  input  logic [4:0]  ex_write_addr,
  input  logic        mem_write_en,
  input  logic [4:0]  mem_write_addr,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        rom_req,
  input  logic        rom_ready,
  input  logic        stall_cnt_clr,
  output logic [5:0]  stall,
  output logic        id_bubble,
  output logic        ex_bubble,
  output logic [1:0]  fwd_sel_1,
  output logic [1:0]  fwd_sel_2,
  output logic        bus_error,
  output logic [15:0] stall_count
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT) > 8) ? $clog2(MEM_TIMEOUT) : 8;
  // Terminal count is one below the timeout: the entry cycle already counts as a wait.
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(MEM_TIMEOUT - 1);

  logic             load_use;
  logic             mem_wait;
  logic             fetch_wait;
  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  hazard_detect u_hazard_detect (
    .id_read_en_1   (id_read_en_1),
    .id_read_en_2   (id_read_en_2),
    .id_read_addr_1 (id_read_addr_1),
    .id_read_addr_2 (id_read_addr_2),
    .ex_write_en    (ex_write_en),
    .ex_load_flag   (ex_load_flag),
    .ex_write_addr  (ex_write_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .fwd_sel_1      (fwd_sel_1),
    .fwd_sel_2      (fwd_sel_2),
    .load_use       (load_use)
  );

  assign mem_wait   = mem_req && !mem_ready;
  assign fetch_wait = rom_req && !rom_ready;

  always_comb begin
    stall     = STALL_NONE;
    id_bubble = 1'b0;
    ex_bubble = 1'b0;
    if (mem_wait) begin
      stall = STALL_DMEM;
    end else if (load_use) begin
      stall     = STALL_LOAD;
      ex_bubble = 1'b1;
    end else if (fetch_wait) begin
      stall     = STALL_FETCH;
      id_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else if (state == ST_RUN) begin
      wait_cnt  <= '0;
      bus_error <= 1'b0;
      if (mem_wait)
        state <= ST_MEM_WAIT;
    end else begin
      if (!mem_wait) begin
        state     <= ST_RUN;
        wait_cnt  <= '0;
        bus_error <= 1'b0;
      end else if (wait_cnt == TIMEOUT_TC) begin
        wait_cnt  <= '0;
        bus_error <= 1'b1;
      end else begin
        wait_cnt  <= wait_cnt + 1'b1;
        bus_error <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= 16'h0000;
    else if (stall_cnt_clr)
      stall_count <= 16'h0000;
    else if (stall[STALL_PC] && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'h0001;
  end

endmodule
